// File: rtl/sdram_ch2_arbiter.sv
// Three-requester round-robin front end for the secondary SDRAM channel.
// Turns one-cycle strobes into the level-held ch2 handshake.
module sdram_ch2_arbiter #(
  parameter int RD_DATA_DELAY = 12,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic [20:0] p0_addr,
  input  logic [15:0] p0_din,
  input  logic [1:0]  p0_wr,
  input  logic        p0_rd,
  output logic [15:0] p0_dout,
  output logic        p0_busy,
  input  logic [20:0] p1_addr,
  input  logic [15:0] p1_din,
  input  logic [1:0]  p1_wr,
  input  logic        p1_rd,
  output logic [15:0] p1_dout,
  output logic        p1_busy,
  input  logic [20:0] p2_addr,
  input  logic [15:0] p2_din,
  input  logic [1:0]  p2_wr,
  input  logic        p2_rd,
  output logic [15:0] p2_dout,
  output logic        p2_busy,
  output logic [20:0] ch2_addr,
  output logic [15:0] ch2_din,
  output logic [1:0]  ch2_wr,
  output logic        ch2_rd,
  input  logic [15:0] ch2_dout,
  input  logic        ch2_rdy,
  output logic        err,
  output logic [2:0]  dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = (RD_DATA_DELAY > 1) ? $clog2(RD_DATA_DELAY) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] D_LOAD = DW'(RD_DATA_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RDLY  = 3'd3,
    S_DONE  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic [20:0] addr;
    logic [15:0] din;
    logic [1:0]  wr;
    logic        rd;
  } slot_t;

  state_t        state;
  slot_t         slot [3];
  logic [2:0]    pend;
  logic [15:0]   dout_r [3];
  logic [1:0]    last_grant;
  logic [1:0]    cur;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] dcnt;

  logic [20:0] in_addr [3];
  logic [15:0] in_din [3];
  logic [1:0]  in_wr [3];
  logic [2:0]  in_rd;
  logic [2:0]  stb;

  always_comb begin
    in_addr[0] = p0_addr;
    in_addr[1] = p1_addr;
    in_addr[2] = p2_addr;
    in_din[0]  = p0_din;
    in_din[1]  = p1_din;
    in_din[2]  = p2_din;
    in_wr[0]   = p0_wr;
    in_wr[1]   = p1_wr;
    in_wr[2]   = p2_wr;
    in_rd      = {p2_rd, p1_rd, p0_rd};
    for (int i = 0; i < 3; i++) begin
      stb[i] = in_rd[i] | (|in_wr[i]);
    end
  end

  // Scan from farthest to nearest so the port right after last_grant wins.
  logic [1:0] gnt;
  logic [1:0] cand;
  logic       gnt_ok;

  always_comb begin
    gnt    = 2'd0;
    cand   = 2'd0;
    gnt_ok = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((32'(last_grant) + 32'(k)) % 32'd3);
      if (pend[cand]) begin
        gnt    = cand;
        gnt_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ch2_addr   <= '0;
      ch2_din    <= '0;
      ch2_wr     <= '0;
      ch2_rd     <= 1'b0;
      err        <= 1'b0;
      pend       <= '0;
      last_grant <= 2'd2;
      cur        <= 2'd0;
      tcnt       <= '0;
      dcnt       <= '0;
      for (int i = 0; i < 3; i++) begin
        slot[i]   <= '0;
        dout_r[i] <= 16'hFFFF;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stb[i] && !pend[i]) begin
          slot[i].addr <= in_addr[i];
          slot[i].din  <= in_din[i];
          slot[i].wr   <= in_wr[i];
          slot[i].rd   <= in_rd[i] & ~(|in_wr[i]);
          pend[i]      <= 1'b1;
        end
      end
      case (state)
        S_IDLE: begin
          if (mem_ready && gnt_ok) begin
            ch2_addr   <= slot[gnt].addr;
            ch2_din    <= slot[gnt].din;
            ch2_wr     <= slot[gnt].wr;
            ch2_rd     <= slot[gnt].rd;
            cur        <= gnt;
            last_grant <= gnt;
            tcnt       <= '0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (state == S_ISSUE && !ch2_rdy) begin
            state <= S_WAIT;
          end else if (state == S_WAIT && ch2_rdy) begin
            if (ch2_rd) begin
              dcnt  <= D_LOAD;
              state <= S_RDLY;
            end else begin
              ch2_wr <= '0;
              state  <= S_DONE;
            end
          end else if (tcnt == T_LAST) begin
            err <= 1'b1;
            if (ch2_rd) dout_r[cur] <= 16'hFFFF;
            ch2_wr <= '0;
            ch2_rd <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_RDLY: begin
          if (dcnt == '0) begin
            dout_r[cur] <= ch2_dout;
            ch2_rd      <= 1'b0;
            state       <= S_DONE;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        S_DONE: begin
          pend[cur] <= 1'b0;
          state     <= S_GAP;
        end
        S_GAP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign p0_busy   = pend[0];
  assign p1_busy   = pend[1];
  assign p2_busy   = pend[2];
  assign p0_dout   = dout_r[0];
  assign p1_dout   = dout_r[1];
  assign p2_dout   = dout_r[2];
  assign dbg_state = state;

endmodule

// File: tb/tb_sdram_ch2_arbiter.sv
// Scoreboard bench for sdram_ch2_arbiter with a behavioural ch2 controller.
// Directed plan scenarios followed by randomized multi-port traffic.
module tb_sdram_ch2_arbiter;

  localparam int RDD = 12;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_ready;
  logic [20:0] a_addr [3];
  logic [15:0] a_din [3];
  logic [1:0]  a_wr [3];
  logic        a_rd [3];
  logic [15:0] dout [3];
  logic [2:0]  busy;
  logic [20:0] ch2_addr;
  logic [15:0] ch2_din;
  logic [1:0]  ch2_wr;
  logic        ch2_rd;
  logic [15:0] ch2_dout;
  logic        ch2_rdy;
  logic        err;
  logic [2:0]  dbg_state;

  sdram_ch2_arbiter #(.RD_DATA_DELAY(RDD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready),
    .p0_addr(a_addr[0]), .p0_din(a_din[0]), .p0_wr(a_wr[0]),
    .p0_rd(a_rd[0]), .p0_dout(dout[0]), .p0_busy(busy[0]),
    .p1_addr(a_addr[1]), .p1_din(a_din[1]), .p1_wr(a_wr[1]),
    .p1_rd(a_rd[1]), .p1_dout(dout[1]), .p1_busy(busy[1]),
    .p2_addr(a_addr[2]), .p2_din(a_din[2]), .p2_wr(a_wr[2]),
    .p2_rd(a_rd[2]), .p2_dout(dout[2]), .p2_busy(busy[2]),
    .ch2_addr(ch2_addr), .ch2_din(ch2_din), .ch2_wr(ch2_wr),
    .ch2_rd(ch2_rd), .ch2_dout(ch2_dout), .ch2_rdy(ch2_rdy),
    .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [20:0] addr;
    logic [15:0] din;
    logic [1:0]  wr;
    logic        rd;
    logic [15:0] exp_dout;
    bit          started;
  } xact_t;

  xact_t sb[$];
  int    grant_log[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] rd_val(input logic [20:0] a);
    if (a == 21'h000100) return 16'hBEEF;
    return a[15:0] ^ {a[20:17], 12'h5C3};
  endfunction

  // Controller model: rdy drops lo cycles after the request edge, rises
  // hi cycles later; read data appears RDD cycles after the rise.
  bit   hang = 1'b0;
  bit   rand_lat = 1'b0;
  int   lat_lo = 2;
  int   lat_hi = 9;
  int   phase = 0;
  int   cnt = 0;
  int   hi_cur = 0;
  logic c_req;
  logic c_prev = 1'b0;

  always @(negedge clk) begin
    c_req = (|ch2_wr) | ch2_rd;
    if (reset || (phase != 0 && !c_req)) begin
      phase    = 0;
      ch2_rdy  = 1'b1;
      ch2_dout = 16'hDEAD;
    end else begin
      case (phase)
        0: if (c_req && !c_prev) begin
          cnt    = rand_lat ? int'($urandom_range(1, 4)) : lat_lo;
          hi_cur = rand_lat ? int'($urandom_range(1, 6)) : lat_hi;
          phase  = hang ? 9 : 1;
        end
        1: begin
          cnt--;
          if (cnt == 0) begin
            ch2_rdy = 1'b0;
            cnt     = hi_cur;
            phase   = 2;
          end
        end
        2: begin
          cnt--;
          if (cnt == 0) begin
            ch2_rdy = 1'b1;
            cnt     = RDD;
            phase   = 3;
          end
        end
        3: begin
          cnt--;
          ch2_dout = ch2_dout + 16'h1111;
          if (cnt == 0) begin
            ch2_dout = rd_val(ch2_addr);
            phase    = 4;
          end
        end
        default: ;
      endcase
    end
    c_prev = c_req;
  end

  // Monitor: pairs each ch2 transfer and each busy fall with the scoreboard.
  logic        m_req;
  logic        m_prev_req = 1'b0;
  logic [2:0]  m_prev_busy = 3'b000;
  int          lo_cnt = 99;
  int          hi_len = 0;
  int          last_hi_len = 0;
  int          n_xfer = 0;
  int          m_idx;
  logic [20:0] cap_addr;
  logic [15:0] cap_din;
  logic [1:0]  cap_wr;
  logic        cap_rd;
  bit          stab_err;

  always @(negedge clk) begin
    m_req = (|ch2_wr) | ch2_rd;
    if (reset) begin
      m_prev_req  = m_req;
      m_prev_busy = busy;
      lo_cnt      = 99;
    end else begin
      if (m_req && !m_prev_req) begin
        m_idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (m_idx < 0 && !sb[i].started && sb[i].addr == ch2_addr &&
              sb[i].din == ch2_din && sb[i].wr == ch2_wr &&
              sb[i].rd == ch2_rd)
            m_idx = i;
        end
        check("gap_low_cycles", lo_cnt >= 2, 1);
        check("xfer_match", m_idx >= 0, 1);
        if (m_idx >= 0) begin
          sb[m_idx].started = 1'b1;
          grant_log.push_back(sb[m_idx].port);
        end
        cap_addr = ch2_addr;
        cap_din  = ch2_din;
        cap_wr   = ch2_wr;
        cap_rd   = ch2_rd;
        stab_err = 1'b0;
        hi_len   = 0;
        n_xfer++;
      end
      if (m_req) begin
        hi_len++;
        if (ch2_addr !== cap_addr || ch2_din !== cap_din ||
            ch2_wr !== cap_wr || ch2_rd !== cap_rd)
          stab_err = 1'b1;
      end
      if (!m_req && m_prev_req) begin
        check("hold_stable", stab_err, 0);
        last_hi_len = hi_len;
        lo_cnt      = 0;
      end
      if (!m_req && lo_cnt < 1000) lo_cnt++;
      for (int p = 0; p < 3; p++) begin
        if (m_prev_busy[p] && !busy[p]) begin
          m_idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (m_idx < 0 && sb[i].port == p) m_idx = i;
          check($sformatf("p%0d_done_expected", p), m_idx >= 0, 1);
          if (m_idx >= 0) begin
            check($sformatf("p%0d_done_started", p), sb[m_idx].started, 1);
            if (sb[m_idx].rd)
              check($sformatf("p%0d_dout", p), dout[p], sb[m_idx].exp_dout);
            sb.delete(m_idx);
          end
        end
      end
      m_prev_req  = m_req;
      m_prev_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic bit port_busy(input int p);
    foreach (sb[i]) if (sb[i].port == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_req(input int p, input logic [20:0] a,
                         input logic [15:0] d, input logic [1:0] w,
                         input logic r, input bit push);
    xact_t x;
    a_addr[p] = a;
    a_din[p]  = d;
    a_wr[p]   = w;
    a_rd[p]   = r;
    if (push) begin
      x.port     = p;
      x.addr     = a;
      x.din      = d;
      x.wr       = w;
      x.rd       = r && (w == 2'b00);
      x.exp_dout = hang ? 16'hFFFF : rd_val(a);
      x.started  = 1'b0;
      sb.push_back(x);
    end
  endtask

  task automatic clear_strobes();
    for (int i = 0; i < 3; i++) begin
      a_wr[i] = 2'b00;
      a_rd[i] = 1'b0;
    end
  endtask

  task automatic pulse();
    tick();
    clear_strobes();
  endtask

  task automatic drain(input string nm, input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    check({nm, "_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  int exp_rr[4] = '{0, 1, 2, 0};
  int c;
  int nx0;

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_addr[i] = '0;
      a_din[i]  = '0;
    end
    clear_strobes();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ch2_addr", ch2_addr, 0);
    check("rst_ch2_din", ch2_din, 0);
    check("rst_ch2_wr", ch2_wr, 0);
    check("rst_ch2_rd", ch2_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, 0);
    for (int i = 0; i < 3; i++)
      check($sformatf("rst_p%0d_dout", i), dout[i], 16'hFFFF);

    // Requests held off until the controller finishes init
    set_req(0, 21'h0ABCDE, 16'h1234, 2'b10, 1'b0, 1'b1);
    set_req(1, 21'h000222, 16'h0000, 2'b00, 1'b1, 1'b1);
    pulse();
    repeat (20) tick();
    check("init_no_xfer", n_xfer, 0);
    check("init_busy", busy, 3'b011);
    mem_ready = 1'b1;
    drain("init", 300);
    check("init_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);

    set_req(0, 21'h012345, 16'hA55A, 2'b11, 1'b0, 1'b1);
    pulse();
    drain("single_wr", 300);
    check("wr_hold_ge_11", last_hi_len >= 11, 1);

    set_req(1, 21'h000100, 16'h0000, 2'b00, 1'b1, 1'b1);
    pulse();
    drain("read_beef", 300);

    nx0 = n_xfer;
    set_req(2, 21'h1F0F0F, 16'h00C3, 2'b01, 1'b1, 1'b1);
    pulse();
    tick();
    set_req(2, 21'h155555, 16'h7777, 2'b10, 1'b0, 1'b0);
    pulse();
    drain("collision", 300);
    check("collision_xfers", n_xfer - nx0, 1);

    grant_log.delete();
    set_req(0, 21'h000010, 16'h1111, 2'b11, 1'b0, 1'b1);
    set_req(1, 21'h000020, 16'h0000, 2'b00, 1'b1, 1'b1);
    set_req(2, 21'h000030, 16'h3333, 2'b10, 1'b0, 1'b1);
    pulse();
    c = 0;
    while (port_busy(0) && c < 300) begin
      tick();
      c++;
    end
    check("rr_p0_first_done", port_busy(0), 0);
    set_req(0, 21'h000040, 16'h0000, 2'b00, 1'b1, 1'b1);
    pulse();
    drain("round_robin", 600);
    check("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size())
        check($sformatf("rr_grant%0d", i), grant_log[i], exp_rr[i]);

    set_req(0, 21'h000123, 16'h0000, 2'b00, 1'b1, 1'b1);
    pulse();
    drain("pre_timeout_rd", 300);
    check("err_before_timeout", err, 0);
    hang = 1'b1;
    set_req(0, 21'h000777, 16'h0000, 2'b00, 1'b1, 1'b1);
    pulse();
    drain("timeout", 500);
    hang = 1'b0;
    check("timeout_err", err, 1);
    check("timeout_len", last_hi_len, TMO);
    set_req(1, 21'h000888, 16'h4242, 2'b11, 1'b0, 1'b1);
    pulse();
    drain("after_timeout", 300);
    check("err_sticky", err, 1);

    lat_lo = 1;
    lat_hi = 40;
    set_req(1, 21'h000321, 16'h0000, 2'b00, 1'b1, 1'b1);
    set_req(2, 21'h000654, 16'h9999, 2'b11, 1'b0, 1'b1);
    pulse();
    c = 0;
    while (dbg_state != 3'd2 && c < 100) begin
      tick();
      c++;
    end
    check("reach_wait", dbg_state, 3'd2);
    reset = 1'b1;
    sb.delete();
    tick();
    check("rstw_ch2_rd", ch2_rd, 0);
    check("rstw_busy", busy, 0);
    check("rstw_state", dbg_state, 0);
    check("rstw_err", err, 0);
    check("rstw_p1_dout", dout[1], 16'hFFFF);
    reset  = 1'b0;
    lat_lo = 2;
    lat_hi = 9;
    repeat (3) tick();
    check("rstw_no_restart", n_xfer - nx0 > 0 && (|ch2_wr | ch2_rd), 0);

    rand_lat = 1'b1;
    for (int n = 0; n < 400; n++) begin
      clear_strobes();
      for (int p = 0; p < 3; p++) begin
        int r;
        int k;
        r = int'($urandom_range(0, 9));
        k = int'($urandom_range(0, 2));
        if (r < 2 && !port_busy(p))
          set_req(p, 21'($urandom), 16'($urandom),
                  k == 0 ? 2'b00 : 2'($urandom_range(1, 3)),
                  k != 1, 1'b1);
        else if (r == 2 && port_busy(p))
          set_req(p, 21'($urandom), 16'($urandom), 2'b01, 1'b0, 1'b0);
      end
      tick();
    end
    clear_strobes();
    drain("random", 3000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_ch2_arbiter.md
Name: sdram_ch2_arbiter

Overview:
- Shares the single 16-bit secondary SDRAM channel (ch2: address, data, byte-write, read strobe, ready) between three requesters, e.g. CD buffer, cartridge RAM and backup RAM.
- Converts each requester's one-cycle strobe into the level-held, edge-detected ch2 protocol.
- Round-robin arbitration between requesters; waits out read-data latency; guards against a hung channel with a timeout.

Parameters:
- RD_DATA_DELAY, 12: cycles after ch2_rdy rises on a read before ch2_dout is sampled; must cover controller CAS and pipeline latency.
- TIMEOUT, 255: maximum cycles spent in ISSUE+WAIT before the transfer is aborted.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller
- reset  in  1  synchronous, active-high
- mem_ready  in  1  controller init complete; no issue while low
- pN_addr (N=0..2)  in  21  word address [21:1]
- pN_din  in  16  write data
- pN_wr  in  2  byte-write strobe {hi,lo}, one-cycle pulse
- pN_rd  in  1  read strobe, one-cycle pulse
- pN_dout  out  16  read data, valid when pN_busy falls after a read
- pN_busy  out  1  request accepted and not yet complete
- ch2_addr  out  21  to controller
- ch2_din  out  16  to controller
- ch2_wr  out  2  to controller, level-held
- ch2_rd  out  1  to controller, level-held
- ch2_dout  in  16  from controller
- ch2_rdy  in  1  from controller; low while a request is pending
- err  out  1  sticky timeout flag
- dbg_state  out  3  FSM state

Behaviour:
- Reset values: ch2_addr=0, ch2_din=0, ch2_wr=0, ch2_rd=0, all pN_busy=0, all pN_dout=16'hFFFF, err=0, FSM=IDLE, last_grant=2 (so p0 wins first).
- Request capture, per port:
  - A strobe (pN_rd or |pN_wr) while pN_busy=0 latches addr, din, wr and type into that port's slot.
  - pN_busy=1 from the next cycle.
  - If rd and wr strobe together, it is a write; rd is ignored.
  - Strobes while pN_busy=1 are ignored.
- IDLE:
  - If mem_ready=1 and any slot is pending, grant round-robin starting at last_grant+1 (mod 3).
  - Next cycle enters ISSUE with ch2_addr, ch2_din and ch2_wr/ch2_rd registered from the granted slot; last_grant is updated.
- ISSUE:
  - Outputs are held stable.
  - On sampling ch2_rdy=0, go to WAIT.
  - ch2_rdy stays high at least 1 cycle after assertion (controller registers its edge detect), so ch2_rdy=1 in the first ISSUE cycle is not completion.
- WAIT:
  - Outputs held. On ch2_rdy=1:
    - Write: go to DONE.
    - Read: go to RDLY, loading a counter with RD_DATA_DELAY-1.
- RDLY: count down to 0, then sample ch2_dout into pN_dout of the granted port and go to DONE.
- DONE (1 cycle):
  - ch2_wr=0, ch2_rd=0.
  - Granted pN_busy=0 on the next clock edge.
  - Slot cleared; go to GAP.
- GAP (1 cycle): ch2_wr/ch2_rd remain low, so they are low for at least 2 cycles between transfers and the controller sees a fresh edge. Then go to IDLE.
- Timeout:
  - A counter resets on entry to ISSUE and increments in ISSUE and WAIT.
  - On reaching TIMEOUT: err=1 (sticky until reset), pN_dout=16'hFFFF for a read, go to DONE.
- Latency:
  - Write, idle bus: strobe to busy fall = 4 + (controller cycles to ch2_rdy low, then high).
  - Read adds RD_DATA_DELAY.
- Simultaneous events:
  - A new strobe on a port in the same cycle its busy falls is accepted, because busy is already 0 that cycle.
  - Strobes from other ports during a transfer queue in their slots.
- mem_ready low: no grants issued; a transfer already in ISSUE/WAIT continues.
- Reset mid-transfer: all outputs return to reset values immediately on the reset edge; pending slots are discarded.
- ch2_addr and ch2_din change only on entry to ISSUE.

Test Plan:
- Single write: p0_wr=2'b11 pulse, addr=21'h012345, din=16'hA55A; model drops rdy 2 cycles after ch2_wr and raises it 9 later -> ch2_wr held 11+ cycles with stable addr/din, p0_busy falls, then ch2_wr low ≥2 cycles.
- Read latency: p1_rd at addr 21'h000100; model returns 16'hBEEF valid RD_DATA_DELAY cycles after rdy rises -> p1_dout=16'hBEEF when busy falls, never an earlier value.
- Round-robin: p0, p1, p2 all strobe in the same cycle, then p0 again immediately after its completion -> grant order 0,1,2,0.
- Collision: p2_rd and p2_wr=2'b01 in the same cycle -> write issued with ch2_wr=2'b01, ch2_rd=0; a strobe while p2_busy=1 produces no extra transfer.
- Timeout: model keeps ch2_rdy=1 forever -> after 255 cycles err=1, p0_dout=16'hFFFF, busy falls; next request still serviced.
- Init/reset: requests with mem_ready=0 -> no ch2 activity until mem_ready=1; reset asserted in WAIT -> ch2_rd=0 and all busy=0 on the next cycle.
